// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester, UART transmitter and grant signals shared by the arbiter and its environment
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_busy;
  logic tx_done;
  logic grant_valid;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic pkt_abort;
  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input req_ready, tx_start, tx_data, grant_valid, grant_id, pkt_abort
  );
  modport slave (
    input req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data, grant_valid, grant_id, pkt_abort
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-locking arbiter feeding one UART transmitter
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  uart_tx_arb_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] gid_q, gid_d, rr_q, rr_d, pick, rr_next;
  logic [7:0] data_q, data_d;
  logic last_q, last_d, sent_q, sent_d;
  logic [15:0] cnt_q, cnt_d;
  logic [IW:0] sum;
  logic [NUM_REQ-1:0] ready;
  logic tx_start, abort, cur_valid;
  assign rr_next = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
  assign cur_valid = bus.req_valid[gid_q];
  // search origin rotates to rr_q; smaller offsets are visited last so they win
  always_comb begin
    pick = rr_q;
    sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (IW+1)'(k);
      sum = (sum >= (IW+1)'(NUM_REQ)) ? sum - (IW+1)'(NUM_REQ) : sum;
      pick = bus.req_valid[sum[IW-1:0]] ? sum[IW-1:0] : pick;
    end
  end
  always_comb begin
    state_d = state_q;
    gid_d = gid_q;
    rr_d = rr_q;
    data_d = data_q;
    last_d = last_q;
    sent_d = sent_q;
    cnt_d = '0;
    ready = '0;
    tx_start = 1'b0;
    abort = 1'b0;
    case (state_q)
      IDLE: if (|bus.req_valid) begin
        gid_d = pick;
        sent_d = 1'b0;
        state_d = LOAD;
      end
      LOAD: begin
        ready[gid_q] = cur_valid;
        if (cur_valid) begin
          data_d = bus.req_data[8*gid_q +: 8];
          last_d = bus.req_last[gid_q];
          state_d = START;
        end else if (sent_q && cnt_q == 16'(LOCK_TIMEOUT - 1)) begin
          abort = 1'b1;
          rr_d = rr_next;
          state_d = IDLE;
        end else if (sent_q) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      START: if (!bus.tx_busy) begin
        tx_start = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (bus.tx_done) begin
        state_d = last_q ? IDLE : LOAD;
        rr_d = last_q ? rr_next : rr_q;
        sent_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gid_q <= '0;
      rr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      sent_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gid_q <= gid_d;
      rr_q <= rr_d;
      data_q <= data_d;
      last_q <= last_d;
      sent_q <= sent_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.req_ready = ready;
  assign bus.tx_start = tx_start;
  assign bus.tx_data = data_q;
  assign bus.grant_valid = state_q != IDLE;
  assign bus.grant_id = gid_q;
  assign bus.pkt_abort = abort;
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one UART transmitter (legal range 2..8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, meaning the idle cycles tolerated inside a locked packet before the lock is forcibly released (legal range 1..65535).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port req_valid  in  NUM_REQ  per-requester byte valid.
REQ-005 SHALL have port req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-006 SHALL have port req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
REQ-007 SHALL have port req_ready  out  NUM_REQ  per-requester byte-accept strobe.
REQ-008 SHALL have port tx_start  out  1  start pulse to the UART transmitter.
REQ-009 SHALL have port tx_data  out  8  byte to the UART transmitter.
REQ-010 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-011 SHALL have port tx_done  in  1  UART frame complete, 1-cycle pulse.
REQ-012 SHALL have port grant_valid  out  1  a requester currently owns the transmitter.
REQ-013 SHALL have port grant_id  out  clog2(NUM_REQ)  index of the owning requester.
REQ-014 SHALL have port pkt_abort  out  1  1-cycle pulse when a lock is released by timeout.

Function
REQ-015 SHALL implement the states IDLE, LOAD, START and WAIT.
REQ-016 In IDLE, if any req_valid is high, it SHALL grant the first requester with req_valid high, searching upward from rr_ptr with wrap; it SHALL register grant_id, set grant_valid=1 and go to LOAD on the next cycle.
REQ-017 In LOAD, req_ready[grant_id] SHALL equal req_valid[grant_id] combinationally and all other req_ready bits SHALL be 0; on acceptance it SHALL capture the byte and the last flag and go to START.
REQ-018 Requesters SHALL hold req_valid, req_data and req_last stable until accepted; the block SHALL never assert more than one req_ready bit in any cycle.
REQ-019 In START, while tx_busy=1 the block SHALL hold in START with tx_start=0; when tx_busy=0 it SHALL assert tx_start=1 for exactly one cycle and go to WAIT.
REQ-020 tx_data SHALL hold the captured byte, unchanged, from the START cycle through the cycle tx_done is received, because the transmitter reads tx_data live during the frame.
REQ-021 In WAIT, on tx_done=1: if the captured last=0, the block SHALL go to LOAD with the grant retained (packet lock); if last=1, it SHALL go to IDLE, clear grant_valid and set rr_ptr=(grant_id+1) mod NUM_REQ.
REQ-022 tx_done SHALL be ignored in every state except WAIT.
REQ-023 A 16-bit timeout counter SHALL count each cycle spent in LOAD with req_valid[grant_id]=0 after at least one byte of the packet has been sent, and SHALL clear on acceptance or on leaving LOAD.
REQ-024 When the counter reaches LOCK_TIMEOUT-1, the block SHALL pulse pkt_abort for 1 cycle, go to IDLE, clear grant_valid and advance rr_ptr as in REQ-021.
REQ-025 On the first LOAD of a packet the timeout SHALL NOT apply, since the requester was valid at grant.
REQ-026 Requests from non-granted requesters SHALL be ignored until the block returns to IDLE; there SHALL be no preemption.
REQ-027 From IDLE with a request present to the tx_start pulse, the minimum latency SHALL be 3 cycles (IDLE->LOAD->START, tx_start in the START cycle) when tx_busy=0.
REQ-028 A single-byte packet SHALL release the grant on its tx_done; from tx_done to the next IDLE arbitration SHALL be 1 cycle.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL go to IDLE and set rr_ptr=0, grant_id=0, grant_valid=0, req_ready=0, tx_start=0, tx_data=8'h00, pkt_abort=0 and timeout counter=0.
REQ-030 A reset mid-packet SHALL drop the captured byte and the lock without generating pkt_abort; the environment SHALL reset the UART transmitter together with this block.

Verification
REQ-031 The bench SHALL cover: req 0 alone, byte 8'hA5, last=1, tx_busy=0 -> tx_start 3 cycles after req_valid, tx_data=8'hA5 stable until tx_done, then grant_valid=0 and rr_ptr=1.
REQ-032 The bench SHALL cover: all 4 requesters valid continuously, 1-byte packets -> grant order 0,1,2,3,0 with no requester granted twice in succession.
REQ-033 The bench SHALL cover: req 2 sends a 3-byte packet (8'h11, 8'h22, 8'h33, last on the third) while req 1 is also valid -> the three bytes go out back-to-back on the UART before any req 1 byte.
REQ-034 The bench SHALL cover: locked packet with req_valid low for LOCK_TIMEOUT cycles (LOCK_TIMEOUT=8) -> pkt_abort after exactly 8 idle LOAD cycles, return to IDLE, next requester granted.
REQ-035 The bench SHALL cover: tx_busy held high for 5 cycles on entering START -> tx_start asserts on the first cycle tx_busy=0, exactly once.
REQ-036 The bench SHALL cover: rst asserted in WAIT -> all outputs at reset values on the next cycle, and a spurious tx_done afterwards causes no state change.
